rx_deswizzler: RTL and testbench
================================

// Module: rx_deswizzler
// PURPOSE
//  Receive-side inverse of the TX lane swizzler. The remote TX compacts each LANENUMBER-unit word onto
//  only the lanes it sees block-locked. This block takes the locally block-locked lanes, recompacts their
//  units in ascending lane order, and reassembles full LANENUMBER-unit words for the upper PCS layer.
//  It sits between the RX lane sorter and the RX descrambler/decoder.
// PARAMETERS
//  UNITWIDTH   48  bits per lane unit (same value as `UNITWIDTH)
//  LANENUMBER  4   number of physical lanes (same value as `LANENUMBER)
// PORTS
//  clk                     in   1                   rising-edge clock
//  reset_n                 in   1                   async active-low reset
//  in_enable               in   1                   clock-enable; when 0, all state holds
//  in_blocklock_local      in   LANENUMBER          per-lane block_lock mask
//  in_blocklock_local_en   in   1                   mask update strobe
//  in_rxdata               in   UNITWIDTH*LANENUMBER  lane data; lane i = bits [i*UNITWIDTH +: UNITWIDTH]
//  in_rxdata_valid         in   1                   in_rxdata holds valid units on locked lanes
//  in_flush                in   1                   SYNC boundary; discard residue (TX pad units)
//  out_rxdata              out  UNITWIDTH*LANENUMBER  reassembled word
//  out_rxdata_valid        out  1                   one-cycle strobe per reassembled word
//  out_level               out  $clog2(2*LANENUMBER)  buffered unit count (pos)
//  saved_blocklock         out  LANENUMBER          active lane mask
//  drop_cnt                out  16                  discarded-unit counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): saved_blocklock=all 1s; pos=0; buffer=0; out_rxdata=0; out_rxdata_valid=0; drop_cnt=0.
//  Mask: on an edge with in_enable && in_blocklock_local_en && mask!=0 && mask!=saved_blocklock:
//   - saved_blocklock takes the new mask.
//   - pos is set to 0 and that cycle's input is discarded.
//   - An all-zero mask is ignored (deadlock guard); an equal mask is a no-op.
//  N = popcount(saved_blocklock), 1..LANENUMBER. The N-count is registered with the mask.
//  Buffer: 2*LANENUMBER units; pos ranges 0..LANENUMBER-1 between cycles.
//   - A valid input appends its N locked-lane units at buf[pos..pos+N-1], lowest lane first.
//  Emit: if pos+N >= LANENUMBER, emit buf[0..LANENUMBER-1] on the next edge:
//   - out_rxdata_valid=1 for 1 cycle.
//   - Shift the buffer down by LANENUMBER units; pos <= pos+N-LANENUMBER.
//   - Otherwise out_rxdata_valid=0 and pos <= pos+N.
//   - At most 1 word per cycle. Overflow cannot occur (pos+N <= 2*LANENUMBER-1).
//  Latency: 1 cycle from the input that completes a word to out_rxdata_valid.
//  Bypass: saved_blocklock all 1s -> out_rxdata <= in_rxdata and out_rxdata_valid <= in_rxdata_valid.
//   pos stays 0.
//  Flush: in_flush in the same cycle as data -> append, emit if complete, then discard the remainder.
//   pos <= 0; the discarded count is the remainder.
//  in_enable=0: all state holds; out_rxdata_valid <= 0.
//  Mask change while in_flush: the mask change wins (the buffer clears either way).
//  Reset mid-word: residue is lost and nothing is emitted.
// CONFIGURATION
//  RX_DESWZ_DROPCNT_EN defined:
//   - drop_cnt is a 16-bit saturating count (stops at 16'hFFFF).
//   - Counts units discarded by flush, by mask change (old pos plus that cycle's input units),
//     and by inputs received while in_enable=0.
//  RX_DESWZ_DROPCNT_EN undefined: drop_cnt tied to 16'h0000 and no counter logic is built.
// TESTING
//  1 Mask 4'b1111, valid words W0,W1 back-to-back:
//    -> out_rxdata W0,W1 on cycles +1,+2; out_level=0.
//  2 Mask 4'b0101; inputs lane0/lane2 = {U0,U1} then {U2,U3}:
//    -> one word {U3,U2,U1,U0} one cycle after the 2nd input; pos returns to 0.
//  3 Mask 4'b0111; 4 inputs x 3 units (U0..U11):
//    -> 3 words {U3..U0},{U7..U4},{U11..U8} on the 2nd, 3rd, 4th inputs +1; pos trace 3,2,1,0.
//  4 Mask 4'b0011; 1 input (pos=2), then in_flush with no data:
//    -> no output; pos=0; drop_cnt=2 (macro on) / 0 (macro off).
//  5 pos=3 under 4'b0111, then mask->4'b0001:
//    -> buffer cleared; 4 subsequent inputs give 1 word. A mask=4'b0000 strobe leaves saved_blocklock unchanged.
//  6 reset_n low mid-word, asynchronously between edges:
//    -> outputs and pos go to 0 immediately; saved_blocklock=4'b1111.

Source files
------------

// File: rtl/rx_deswizzler_if.sv
// ---------------------------------------------------------------------------
// rx_deswizzler_if
//   Data-path bundle for the RX deswizzler. It carries lane data, the block-lock
//   mask and the flush strobe into the block, and the reassembled words out.
//   master : the upstream/test side. It drives in_* and observes out_*.
//   slave  : the deswizzler. It consumes in_* and drives out_*.
// Parameters
//   UNITWIDTH  bits per lane unit
//   LANENUMBER number of physical lanes
// ---------------------------------------------------------------------------
interface rx_deswizzler_if #(
    parameter int UNITWIDTH  = 48,
    parameter int LANENUMBER = 4
);
    logic [LANENUMBER-1:0]           in_blocklock_local;
    logic                            in_blocklock_local_en;
    logic [UNITWIDTH*LANENUMBER-1:0] in_rxdata;
    logic                            in_rxdata_valid;
    logic                            in_flush;
    logic [UNITWIDTH*LANENUMBER-1:0] out_rxdata;
    logic                            out_rxdata_valid;

    modport master (
        output in_blocklock_local, in_blocklock_local_en,
        output in_rxdata, in_rxdata_valid, in_flush,
        input  out_rxdata, out_rxdata_valid
    );

    modport slave (
        input  in_blocklock_local, in_blocklock_local_en,
        input  in_rxdata, in_rxdata_valid, in_flush,
        output out_rxdata, out_rxdata_valid
    );
endinterface

// File: rtl/rx_deswizzler.sv
// ---------------------------------------------------------------------------
// rx_deswizzler
//   Receive-side inverse of the TX lane swizzler. The units on the locally
//   block-locked lanes are compacted in ascending lane order into a
//   2*LANENUMBER-unit buffer. Each time LANENUMBER units are available, one
//   full word is emitted. When every lane is locked, the data bypasses the
//   buffer and reaches the output one cycle later.
// Ports
//   clk, reset_n        clock, async active-low reset
//   in_enable           clock enable (0: state holds, no output strobe)
//   bus (slave)         lane data/valid, flush, mask + strobe in; word/valid out
//   out_level           units currently buffered (pos)
//   saved_blocklock     active lane mask
//   drop_cnt            discarded-unit counter
// Build option
//   RX_DESWZ_DROPCNT_EN When defined, drop_cnt is a saturating 16-bit count of
//                       discarded units. When undefined, it is tied to zero.
// ---------------------------------------------------------------------------

// Per-lane placement: the buffer slot for this lane's unit is the current
// fill position plus the number of locked lanes below this one.
module rx_deswizzler_lane #(
    parameter int LANENUMBER = 4,
    parameter int LANE       = 0,
    parameter int PW         = 3
) (
    input  logic [LANENUMBER-1:0] mask,
    input  logic [PW-1:0]         base,
    output logic [PW-1:0]         dest
);
    always_comb begin
        dest = base;
        for (int k = 0; k < LANENUMBER; k++)
            if (k < LANE && mask[k]) dest = dest + PW'(1);
    end
endmodule

module rx_deswizzler #(
    parameter int UNITWIDTH  = 48,
    parameter int LANENUMBER = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_enable,
    rx_deswizzler_if.slave                  bus,
    output logic [$clog2(2*LANENUMBER)-1:0] out_level,
    output logic [LANENUMBER-1:0]           saved_blocklock,
    output logic [15:0]                     drop_cnt
);
    localparam int L  = LANENUMBER;
    localparam int PW = $clog2(2*L);     // pos / buffer index width
    localparam int IW = PW + 1;          // room for pos+N up to 2L-1
    localparam int NW = $clog2(L+1);     // locked-lane count width

    function automatic logic [NW-1:0] popcnt(input logic [L-1:0] m);
        popcnt = '0;
        for (int i = 0; i < L; i++) popcnt = popcnt + NW'(m[i]);
    endfunction

    logic [2*L-1:0][UNITWIDTH-1:0] ubuf_q, merged, nxt_buf;
    logic [PW-1:0]                 pos_q;
    logic [NW-1:0]                 n_q;
    logic [L-1:0][PW-1:0]          dest;
    logic [IW-1:0]                 total, rem;
    logic                          emit, mask_chg, bypass;

    assign out_level = pos_q;
    assign bypass    = &saved_blocklock;

    // An all-zero mask would leave nothing to assemble, so it is ignored.
    assign mask_chg = bus.in_blocklock_local_en && (|bus.in_blocklock_local)
                   && (bus.in_blocklock_local != saved_blocklock);

    for (genvar g = 0; g < L; g++) begin : g_lane
        rx_deswizzler_lane #(.LANENUMBER(L), .LANE(g), .PW(PW)) u_lane (
            .mask (saved_blocklock),
            .base (pos_q),
            .dest (dest[g])
        );
    end

    // Append the locked-lane units behind the current residue.
    always_comb begin
        merged = ubuf_q;
        if (bus.in_rxdata_valid)
            for (int i = 0; i < L; i++)
                if (saved_blocklock[i])
                    merged[dest[i]] = bus.in_rxdata[i*UNITWIDTH +: UNITWIDTH];
    end

    always_comb begin
        total = {1'b0, pos_q} + (bus.in_rxdata_valid ? IW'(n_q) : IW'(0));
        emit  = total >= IW'(L);
        rem   = emit ? total - IW'(L) : total;
        for (int j = 0; j < L; j++)
            nxt_buf[j] = emit ? merged[j+L] : merged[j];
        for (int j = L; j < 2*L; j++)
            nxt_buf[j] = emit ? '0 : merged[j];
        // A flush drops whatever is still short of a full word.
        if (bus.in_flush) nxt_buf = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            saved_blocklock      <= '1;
            n_q                  <= NW'(L);
            pos_q                <= '0;
            ubuf_q               <= '0;
            bus.out_rxdata       <= '0;
            bus.out_rxdata_valid <= 1'b0;
        end else if (!in_enable) begin
            bus.out_rxdata_valid <= 1'b0;
        end else if (mask_chg) begin
            // A realignment takes priority over a flush in the same cycle.
            // This cycle's input still belongs to the old mask, so it is dropped.
            saved_blocklock      <= bus.in_blocklock_local;
            n_q                  <= popcnt(bus.in_blocklock_local);
            pos_q                <= '0;
            ubuf_q               <= '0;
            bus.out_rxdata_valid <= 1'b0;
        end else if (bypass) begin
            bus.out_rxdata       <= bus.in_rxdata;
            bus.out_rxdata_valid <= bus.in_rxdata_valid;
        end else begin
            ubuf_q               <= nxt_buf;
            pos_q                <= bus.in_flush ? '0 : rem[PW-1:0];
            bus.out_rxdata_valid <= emit;
            if (emit) bus.out_rxdata <= merged[L-1:0];
        end
    end

`ifdef RX_DESWZ_DROPCNT_EN
    logic [IW-1:0] drop_add;
    logic [16:0]   drop_sum;
    logic [15:0]   drop_q;

    always_comb begin
        if (!in_enable)
            drop_add = bus.in_rxdata_valid ? IW'(n_q) : '0;
        else if (mask_chg)
            drop_add = total;          // old residue plus this cycle's units
        else if (bus.in_flush)
            drop_add = rem;            // always zero in bypass
        else
            drop_add = '0;
    end

    assign drop_sum = {1'b0, drop_q} + 17'(drop_add);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        drop_q <= '0;
        else if (drop_sum[16]) drop_q <= 16'hFFFF;
        else                 drop_q <= drop_sum[15:0];
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_deswizzler.sv
module tb_rx_deswizzler;
    localparam int UW = 48;
    localparam int L  = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_enable = 1'b0;
    logic [2:0]  out_level;
    logic [3:0]  saved_blocklock;
    logic [15:0] drop_cnt;

    rx_deswizzler_if #(.UNITWIDTH(UW), .LANENUMBER(L)) bus ();

    rx_deswizzler #(.UNITWIDTH(UW), .LANENUMBER(L)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_enable       (in_enable),
        .bus             (bus),
        .out_level       (out_level),
        .saved_blocklock (saved_blocklock),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a FIFO of units. The buffer, pos and lane ranking are
    // not represented directly.
    logic [UW-1:0]   mq[$];
    logic [3:0]      m_mask = 4'hF;
    int              m_drop = 0;
    logic [UW*L-1:0] m_word = '0;
    bit              m_valid = 1'b0;

    function automatic int exp_drop();
`ifdef RX_DESWZ_DROPCNT_EN
        return (m_drop > 65535) ? 65535 : m_drop;
`else
        return 0;
`endif
    endfunction

    function automatic logic [UW*L-1:0] rnd_word();
        logic [UW*L-1:0] w;
        for (int i = 0; i < (UW*L)/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [UW*L-1:0] pack_units(input logic [UW-1:0] u0, u1, u2, u3);
        return {u3, u2, u1, u0};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mask = 4'hF;
        m_drop = 0;
        m_valid = 1'b0;
    endtask

    // Drive one cycle, advance the model, and return 1 time unit after the edge.
    task automatic step(input bit en, input bit v, input bit fl, input bit men,
                        input logic [3:0] mk, input logic [UW*L-1:0] d);
        in_enable                 = en;
        bus.in_rxdata_valid       = v;
        bus.in_flush              = fl;
        bus.in_blocklock_local_en = men;
        bus.in_blocklock_local    = mk;
        bus.in_rxdata             = d;
        @(posedge clk);
        m_valid = 1'b0;
        if (!en) begin
            if (v) m_drop += $countones(m_mask);
        end else if (men && mk != 4'h0 && mk != m_mask) begin
            m_drop += mq.size() + (v ? $countones(m_mask) : 0);
            mq.delete();
            m_mask = mk;
        end else begin
            if (v)
                for (int i = 0; i < L; i++)
                    if (m_mask[i]) mq.push_back(d[i*UW +: UW]);
            if (mq.size() >= L) begin
                m_word = {mq[3], mq[2], mq[1], mq[0]};
                repeat (L) void'(mq.pop_front());
                m_valid = 1'b1;
            end
            if (fl) begin
                m_drop += mq.size();
                mq.delete();
            end
        end
        #1;
        in_enable                 = 1'b1;
        bus.in_rxdata_valid       = 1'b0;
        bus.in_flush              = 1'b0;
        bus.in_blocklock_local_en = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (bus.out_rxdata_valid !== 1'b0 || bus.out_rxdata !== '0 || out_level !== 3'd0 ||
            saved_blocklock !== 4'hF || drop_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset: valid=%b data=%h level=%0d mask=%b drop=%0d, required 0/0/0/1111/0",
                     bus.out_rxdata_valid, bus.out_rxdata, out_level, saved_blocklock, drop_cnt);
        end
    endtask

    task automatic test_bypass();
        logic [UW*L-1:0] w0, w1;
        w0 = rnd_word();
        w1 = rnd_word();
        step(1, 1, 0, 0, 4'h0, w0);
        total++;
        if (bus.out_rxdata_valid !== 1'b1 || bus.out_rxdata !== w0 || out_level !== 3'd0) begin
            bad++;
            $display("FAIL bypass_w0: valid=%b data=%h level=%0d, required 1 %h 0",
                     bus.out_rxdata_valid, bus.out_rxdata, out_level, w0);
        end
        step(1, 1, 0, 0, 4'h0, w1);
        total++;
        if (bus.out_rxdata_valid !== 1'b1 || bus.out_rxdata !== w1 || out_level !== 3'd0) begin
            bad++;
            $display("FAIL bypass_w1: valid=%b data=%h level=%0d, required 1 %h 0",
                     bus.out_rxdata_valid, bus.out_rxdata, out_level, w1);
        end
        step(1, 0, 0, 0, 4'h0, '0);
        total++;
        if (bus.out_rxdata_valid !== 1'b0) begin
            bad++;
            $display("FAIL bypass_idle: valid=%b, required 0", bus.out_rxdata_valid);
        end
    endtask

    task automatic test_mask_0101();
        logic [UW-1:0] u[4];
        for (int i = 0; i < 4; i++) u[i] = {$urandom, 16'(i)};
        step(1, 1, 0, 1, 4'b0101, rnd_word());   // this cycle's input is discarded
        step(1, 1, 0, 0, 4'h0, pack_units(u[0], 48'h0, u[1], 48'h0));
        total++;
        if (bus.out_rxdata_valid !== 1'b0 || out_level !== 3'd2 || saved_blocklock !== 4'b0101) begin
            bad++;
            $display("FAIL m0101_first: valid=%b level=%0d mask=%b, required 0 2 0101",
                     bus.out_rxdata_valid, out_level, saved_blocklock);
        end
        step(1, 1, 0, 0, 4'h0, pack_units(u[2], 48'h0, u[3], 48'h0));
        total++;
        if (bus.out_rxdata_valid !== 1'b1 || bus.out_rxdata !== pack_units(u[0], u[1], u[2], u[3]) ||
            out_level !== 3'd0) begin
            bad++;
            $display("FAIL m0101_word: valid=%b data=%h level=%0d, required 1 %h 0",
                     bus.out_rxdata_valid, bus.out_rxdata, out_level, pack_units(u[0], u[1], u[2], u[3]));
        end
    endtask

    task automatic test_mask_0111();
        int pos_exp[4] = '{3, 2, 1, 0};
        bit vld_exp[4] = '{0, 1, 1, 1};
        step(1, 0, 0, 1, 4'b0111, '0);
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 0, 0, 4'h0, rnd_word());
            total++;
            if (bus.out_rxdata_valid !== vld_exp[k] || out_level !== 3'(pos_exp[k]) ||
                bus.out_rxdata_valid !== m_valid || (m_valid && bus.out_rxdata !== m_word)) begin
                bad++;
                $display("FAIL m0111_in%0d: valid=%b data=%h level=%0d, required %b %h %0d",
                         k, bus.out_rxdata_valid, bus.out_rxdata, out_level, vld_exp[k], m_word, pos_exp[k]);
            end
        end
    endtask

    task automatic test_flush();
        int d0;
        d0 = exp_drop();
        step(1, 0, 0, 1, 4'b0011, '0);
        step(1, 1, 0, 0, 4'h0, rnd_word());
        step(1, 0, 1, 0, 4'h0, '0);
        total++;
        if (bus.out_rxdata_valid !== 1'b0 || out_level !== 3'd0 || int'(drop_cnt) !== exp_drop()) begin
            bad++;
            $display("FAIL flush: valid=%b level=%0d drop=%0d, required 0 0 %0d",
                     bus.out_rxdata_valid, out_level, drop_cnt, exp_drop());
        end
`ifdef RX_DESWZ_DROPCNT_EN
        total++;
        if (int'(drop_cnt) - d0 !== 2) begin
            bad++;
            $display("FAIL flush_delta: drop increase=%0d, required 2", int'(drop_cnt) - d0);
        end
`endif
    endtask

    task automatic test_mask_change();
        int words;
        step(1, 0, 0, 1, 4'b0111, '0);
        step(1, 1, 0, 0, 4'h0, rnd_word());
        total++;
        if (out_level !== 3'd3) begin
            bad++;
            $display("FAIL mchg_pos3: level=%0d, required 3", out_level);
        end
        step(1, 1, 0, 1, 4'b0001, rnd_word());
        total++;
        if (out_level !== 3'd0 || saved_blocklock !== 4'b0001 || int'(drop_cnt) !== exp_drop()) begin
            bad++;
            $display("FAIL mchg_clear: level=%0d mask=%b drop=%0d, required 0 0001 %0d",
                     out_level, saved_blocklock, drop_cnt, exp_drop());
        end
        words = 0;
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 0, 0, 4'h0, rnd_word());
            if (bus.out_rxdata_valid === 1'b1) words++;
            total++;
            if (bus.out_rxdata_valid !== m_valid || (m_valid && bus.out_rxdata !== m_word)) begin
                bad++;
                $display("FAIL mchg_in%0d: valid=%b data=%h, required %b %h",
                         k, bus.out_rxdata_valid, bus.out_rxdata, m_valid, m_word);
            end
        end
        total++;
        if (words !== 1) begin
            bad++;
            $display("FAIL mchg_words: words=%0d, required 1", words);
        end
        step(1, 0, 0, 1, 4'b0000, '0);
        total++;
        if (saved_blocklock !== 4'b0001) begin
            bad++;
            $display("FAIL mask_zero: mask=%b, required 0001", saved_blocklock);
        end
    endtask

    task automatic test_enable();
        step(1, 0, 0, 1, 4'b0011, '0);
        step(1, 1, 0, 0, 4'h0, rnd_word());
        step(0, 1, 0, 0, 4'h0, rnd_word());
        total++;
        if (bus.out_rxdata_valid !== 1'b0 || out_level !== 3'd2 || int'(drop_cnt) !== exp_drop()) begin
            bad++;
            $display("FAIL enable_hold: valid=%b level=%0d drop=%0d, required 0 2 %0d",
                     bus.out_rxdata_valid, out_level, drop_cnt, exp_drop());
        end
    endtask

    task automatic test_random();
        bit en, v, fl, men;
        logic [3:0] mk;
        for (int k = 0; k < 400; k++) begin
            en  = ($urandom_range(0, 19) != 0);
            v   = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 15) == 0);
            men = ($urandom_range(0, 11) == 0);
            mk  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom);
            step(en, v, fl, men, mk, rnd_word());
            total++;
            if (bus.out_rxdata_valid !== m_valid || (m_valid && bus.out_rxdata !== m_word) ||
                out_level !== 3'(mq.size()) || saved_blocklock !== m_mask ||
                int'(drop_cnt) !== exp_drop()) begin
                bad++;
                $display("FAIL random_%0d: valid=%b/%b data=%h/%h level=%0d/%0d mask=%b/%b drop=%0d/%0d",
                         k, bus.out_rxdata_valid, m_valid, bus.out_rxdata, m_word, out_level, mq.size(),
                         saved_blocklock, m_mask, drop_cnt, exp_drop());
            end
        end
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 1, 4'b0111, '0);
        step(1, 1, 0, 0, 4'h0, rnd_word());
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (bus.out_rxdata_valid !== 1'b0 || bus.out_rxdata !== '0 || out_level !== 3'd0 ||
            saved_blocklock !== 4'hF || drop_cnt !== 16'h0) begin
            bad++;
            $display("FAIL async_reset: valid=%b data=%h level=%0d mask=%b drop=%0d, required 0/0/0/1111/0",
                     bus.out_rxdata_valid, bus.out_rxdata, out_level, saved_blocklock, drop_cnt);
        end
        @(negedge clk) reset_n = 1'b1;
        step(1, 1, 0, 0, 4'h0, rnd_word());
        total++;
        if (bus.out_rxdata_valid !== 1'b1 || bus.out_rxdata !== m_word) begin
            bad++;
            $display("FAIL post_reset: valid=%b data=%h, required 1 %h",
                     bus.out_rxdata_valid, bus.out_rxdata, m_word);
        end
    endtask

    initial begin
        bus.in_rxdata_valid       = 1'b0;
        bus.in_flush              = 1'b0;
        bus.in_blocklock_local_en = 1'b0;
        bus.in_blocklock_local    = 4'h0;
        bus.in_rxdata             = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) reset_n = 1'b1;
        in_enable = 1'b1;
        test_bypass();
        test_mask_0101();
        test_mask_0111();
        test_flush();
        test_mask_change();
        test_enable();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
